// File: rtl/tx_huge_page_rd_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_page_rd_req_pkg
// Purpose  : Shared constants for the huge-page read-request path. Holds the
//            TLP fmt/type codes, the DW0 field positions, the FSM state
//            encodings, the default read chunk size and a DW0 builder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tx_huge_page_rd_req_pkg;

  // TLP fmt/type codes, placed in DW0 bits [30:24]
  localparam logic [6:0] c_FMT_TYPE_MRD64 = 7'b01_00000;
  localparam logic [6:0] c_FMT_TYPE_MWR32 = 7'b10_00000;
  localparam logic [6:0] c_FMT_TYPE_MWR64 = 7'b11_00000;

  // DW0 field positions
  localparam int c_DW0_FMT_TYPE_LSB = 24;
  localparam int c_DW0_TC_LSB       = 20;
  localparam int c_DW0_ATTR_LSB     = 12;
  localparam int c_DW0_LEN_LSB      = 0;

  // Largest MRd payload requested by default, in qwords
  localparam int c_DEFAULT_MAX_RD_QWORDS = 64;

  // Request FSM state encodings
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHK   = 3'd1;
  localparam logic [2:0] S_HDR0  = 3'd2;
  localparam logic [2:0] S_HDR1  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FREE  = 3'd5;

  // DW0 of an MRd64 with TC=0, attr=0, TD=0, EP=0. A length of 0 means
  // 1024 DW, so callers simply truncate chunk*2 to 10 bits.
  function automatic logic [31:0] mrd64_dw0(input logic [9:0] len_dw);
    logic [31:0] v;
    v = '0;
    v[c_DW0_FMT_TYPE_LSB +: 7] = c_FMT_TYPE_MRD64;
    v[c_DW0_TC_LSB +: 3]       = 3'b000;
    v[c_DW0_ATTR_LSB +: 2]     = 2'b00;
    v[c_DW0_LEN_LSB +: 10]     = len_dw;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_huge_page_rd_req_credit.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_page_rd_req_credit
// Purpose  : Tracks in-flight read requests and hands out request tags.
// Ports    : trn_clk, reset_n (async, active-low)
//            issue     - one request header has just been accepted
//            cpl_done  - one request has fully completed
//            tag       - tag to place in the next request
//            can_issue - fewer than MAX_OUTSTANDING requests in flight
//            idle      - nothing in flight
// Revision : 1.0 - initial release
// ============================================================================
module tx_huge_page_rd_req_credit #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 5
) (
  input  logic             trn_clk,
  input  logic             reset_n,
  input  logic             issue,
  input  logic             cpl_done,
  output logic [TAG_W-1:0] tag,
  output logic             can_issue,
  output logic             idle
);

  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [c_CNT_W-1:0] r_outstanding;
  logic [TAG_W-1:0]   r_tag;
  logic               w_dec;

  // A completion with nothing in flight is spurious and dropped.
  assign w_dec = cpl_done && (r_outstanding != '0);

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_tag         <= '0;
    end else begin
      if (issue) begin
        r_tag <= r_tag + TAG_W'(1);
      end
      case ({issue, w_dec})
        2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign tag       = r_tag;
  assign can_issue = (r_outstanding < c_CNT_W'(MAX_OUTSTANDING));
  assign idle      = (r_outstanding == '0);

endmodule
`default_nettype wire

// File: rtl/tx_huge_page_rd_req.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_page_rd_req
// Purpose  : Reads unlocked huge pages by issuing MRd64 TLPs on the TRN TX
//            interface in chunks of at most MAX_RD_QWORDS. Pages 1 and 2 are
//            served in strict alternation starting with page 1; each page is
//            released with a one-cycle huge_page_free_x pulse after all of its
//            requests are issued and completed.
// Ports    : trn_clk, reset_n (async, active-low), cfg_completer_id
//            TRN TX  : trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
//                      trn_tsrc_rdy_n, trn_tdst_rdy_n
//            Pages   : huge_page_addr_1/2, huge_page_qwords_1/2,
//                      huge_page_status_1/2, huge_page_free_1/2
//            rd_cpl_done - one request fully completed
//            TX_HUGE_PAGE_RD_STATS_EN adds rd_req_count / pages_done_count.
// Revision : 1.0 - initial release
// ============================================================================
module tx_huge_page_rd_req
  import tx_huge_page_rd_req_pkg::*;
#(
  parameter int MAX_RD_QWORDS   = c_DEFAULT_MAX_RD_QWORDS,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 5
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [15:0] cfg_completer_id,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic [31:0] huge_page_qwords_1,
  input  logic [31:0] huge_page_qwords_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic        huge_page_free_1,
  output logic        huge_page_free_2,
  input  logic        rd_cpl_done
`ifdef TX_HUGE_PAGE_RD_STATS_EN
  ,
  output logic [31:0] rd_req_count,
  output logic [31:0] pages_done_count
`endif
);

  logic [2:0]       r_state;
  logic             r_page_sel;   // 0 = page 1, 1 = page 2
  logic [63:0]      r_cur_addr;
  logic [31:0]      r_rem_qw;

  logic [31:0]      w_chunk;
  logic [9:0]       w_len_dw;
  logic [TAG_W-1:0] w_tag;
  logic [7:0]       w_tag8;
  logic             w_can_issue;
  logic             w_idle;
  logic             w_issue;
  logic             w_status_cur;

  assign w_chunk = (r_rem_qw < 32'(MAX_RD_QWORDS)) ? r_rem_qw : 32'(MAX_RD_QWORDS);
  // chunk <= 512 qwords, so chunk*2 fits in 10 bits with 1024 wrapping to 0.
  assign w_len_dw     = {w_chunk[8:0], 1'b0};
  assign w_tag8       = 8'(w_tag);
  assign w_issue      = (r_state == S_HDR1) && !trn_tdst_rdy_n;
  assign w_status_cur = r_page_sel ? huge_page_status_2 : huge_page_status_1;

  tx_huge_page_rd_req_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TAG_W           (TAG_W)
  ) u_credit (
    .trn_clk   (trn_clk),
    .reset_n   (reset_n),
    .issue     (w_issue),
    .cpl_done  (rd_cpl_done),
    .tag       (w_tag),
    .can_issue (w_can_issue),
    .idle      (w_idle)
  );

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_page_sel <= 1'b0;
      r_cur_addr <= '0;
      r_rem_qw   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Only the page the pointer selects is looked at.
          if (w_status_cur) begin
            r_cur_addr <= r_page_sel ? huge_page_addr_2   : huge_page_addr_1;
            r_rem_qw   <= r_page_sel ? huge_page_qwords_2 : huge_page_qwords_1;
            r_state    <= S_CHK;
          end
        end
        S_CHK: begin
          if (r_rem_qw == '0) begin
            r_state <= S_DRAIN;
          end else if (w_can_issue) begin
            r_state <= S_HDR0;
          end
        end
        S_HDR0: begin
          if (!trn_tdst_rdy_n) begin
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (!trn_tdst_rdy_n) begin
            r_cur_addr <= r_cur_addr + 64'({w_chunk, 3'b000});
            r_rem_qw   <= r_rem_qw - w_chunk;
            r_state    <= S_CHK;
          end
        end
        S_DRAIN: begin
          if (w_idle) begin
            r_state <= S_FREE;
          end
        end
        S_FREE: begin
          // Flipping here means IDLE next samples the other page, so the
          // just-freed page's stale status is never seen again.
          r_page_sel <= ~r_page_sel;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // TX outputs decode straight from state so an asynchronous reset drops a
  // frame immediately; they hold still while a beat waits for tdst_rdy.
  always_comb begin
    trn_td = '0;
    case (r_state)
      S_HDR0:  trn_td = {mrd64_dw0(w_len_dw), cfg_completer_id, w_tag8, 4'hF, 4'hF};
      S_HDR1:  trn_td = {r_cur_addr[63:2], 2'b00};
      default: trn_td = '0;
    endcase
  end

  assign trn_trem_n       = 8'h00;
  assign trn_tsrc_rdy_n   = !((r_state == S_HDR0) || (r_state == S_HDR1));
  assign trn_tsof_n       = (r_state != S_HDR0);
  assign trn_teof_n       = (r_state != S_HDR1);
  assign huge_page_free_1 = (r_state == S_FREE) && !r_page_sel;
  assign huge_page_free_2 = (r_state == S_FREE) &&  r_page_sel;

`ifdef TX_HUGE_PAGE_RD_STATS_EN
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_count     <= '0;
      pages_done_count <= '0;
    end else begin
      if (w_issue) begin
        rd_req_count <= rd_req_count + 32'd1;
      end
      if (r_state == S_FREE) begin
        pages_done_count <= pages_done_count + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_huge_page_rd_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_huge_page_rd_req
// Purpose  : Self-checking bench for tx_huge_page_rd_req. A page-level model
//            predicts every MRd64 (length, address, tag, and how many pages
//            must already be freed) and a monitor compares accepted TLPs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_huge_page_rd_req;

  localparam int c_MAX_QW  = 64;
  localparam int c_MAX_OUT = 8;
  localparam int c_TAG_W   = 5;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cfg_completer_id = 16'h0;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic [63:0] huge_page_addr_1 = '0, huge_page_addr_2 = '0;
  logic [31:0] huge_page_qwords_1 = '0, huge_page_qwords_2 = '0;
  logic        huge_page_status_1 = 1'b0, huge_page_status_2 = 1'b0;
  logic        huge_page_free_1, huge_page_free_2;
  logic        rd_cpl_done = 1'b0;
`ifdef TX_HUGE_PAGE_RD_STATS_EN
  logic [31:0] rd_req_count, pages_done_count;
`endif

  always #5 trn_clk = ~trn_clk;

  tx_huge_page_rd_req #(
    .MAX_RD_QWORDS   (c_MAX_QW),
    .MAX_OUTSTANDING (c_MAX_OUT),
    .TAG_W           (c_TAG_W)
  ) dut (
    .trn_clk            (trn_clk),
    .reset_n            (reset_n),
    .cfg_completer_id   (cfg_completer_id),
    .trn_td             (trn_td),
    .trn_trem_n         (trn_trem_n),
    .trn_tsof_n         (trn_tsof_n),
    .trn_teof_n         (trn_teof_n),
    .trn_tsrc_rdy_n     (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n     (trn_tdst_rdy_n),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_qwords_1 (huge_page_qwords_1),
    .huge_page_qwords_2 (huge_page_qwords_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .huge_page_free_1   (huge_page_free_1),
    .huge_page_free_2   (huge_page_free_2),
    .rd_cpl_done        (rd_cpl_done)
`ifdef TX_HUGE_PAGE_RD_STATS_EN
    ,
    .rd_req_count       (rd_req_count),
    .pages_done_count   (pages_done_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [9:0]  len;
    logic [63:0] addr;
    logic [7:0]  tag;
    int          frees;
  } tlp_t;

  tlp_t exp_q[$];
  int   exp_tag     = 0;
  int   model_frees = 0;

  task automatic push_page(input logic [63:0] a, input int qw);
    logic [63:0] addr;
    int r, c;
    tlp_t t;
    addr = a;
    r    = qw;
    while (r > 0) begin
      c       = (r < c_MAX_QW) ? r : c_MAX_QW;
      t.len   = 10'((c * 2) % 1024);
      t.addr  = addr;
      t.tag   = 8'(exp_tag);
      t.frees = model_frees;
      exp_q.push_back(t);
      exp_tag = (exp_tag + 1) % (1 << c_TAG_W);
      addr    = addr + 64'(c * 8);
      r       = r - c;
    end
    model_frees++;
  endtask

  task automatic set_page(input int p, input logic [63:0] a, input int qw);
    if (p == 1) begin
      huge_page_addr_1 = a; huge_page_qwords_1 = 32'(qw);
    end else begin
      huge_page_addr_2 = a; huge_page_qwords_2 = 32'(qw);
    end
    push_page(a, qw);
  endtask

  function automatic logic [63:0] rand_page_addr();
    return {32'($urandom), 20'($urandom), 12'h000};
  endfunction

  // ---------------- monitor ----------------
  int          n_issued = 0;
  int          n_cpl    = 0;
  int          n_free   = 0;
  bit          hdr_seen = 0;
  bit          prev_wait = 0;
  bit          prev_free = 0;
  logic [63:0] hdr_dw, prev_td;
  logic [1:0]  prev_fr;
  tlp_t        mon_e;

  always @(negedge trn_clk) begin
    if (!reset_n) begin
      hdr_seen  = 0;
      prev_wait = 0;
      prev_free = 0;
      n_issued  = n_cpl;
    end else begin
      if (prev_wait) begin
        check("beat_dropped", 64'(trn_tsrc_rdy_n), 64'd0);
        check("hold_td", trn_td, prev_td);
        check("hold_sof_eof", 64'({trn_tsof_n, trn_teof_n}), 64'(prev_fr));
      end
      prev_wait = 0;
      if (!trn_tsrc_rdy_n) begin
        if (!trn_tdst_rdy_n) begin
          if (!hdr_seen) begin
            check("beat1_sof_eof", 64'({trn_tsof_n, trn_teof_n}), 64'd1);
            hdr_dw   = trn_td;
            hdr_seen = 1;
          end else begin
            check("beat2_sof_eof", 64'({trn_tsof_n, trn_teof_n}), 64'd2);
            hdr_seen = 0;
            n_issued++;
            check("outstanding_max", 64'((n_issued - n_cpl) <= c_MAX_OUT), 64'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_tlp", 64'd1, 64'd0);
            end else begin
              mon_e = exp_q.pop_front();
              check("dw0", 64'(hdr_dw[63:32]), 64'(32'h2000_0000 | 32'(mon_e.len)));
              check("dw1", 64'(hdr_dw[31:0]), 64'({cfg_completer_id, mon_e.tag, 8'hFF}));
              check("addr", trn_td, mon_e.addr);
              check("page_order", 64'(n_free), 64'(mon_e.frees));
            end
          end
        end else begin
          prev_wait = 1;
          prev_td   = trn_td;
          prev_fr   = {trn_tsof_n, trn_teof_n};
        end
      end
      if (huge_page_free_1 || huge_page_free_2) begin
        check("free_width", 64'(prev_free), 64'd0);
        check("free_both", 64'(huge_page_free_1 && huge_page_free_2), 64'd0);
        check("free_drained", 64'(n_issued - n_cpl), 64'd0);
        n_free++;
      end
      prev_free = huge_page_free_1 || huge_page_free_2;
    end
  end

  // ---------------- completer and sink ----------------
  bit auto_cpl   = 0;
  int cpl_budget = 0;
  int rdy_mode   = 0;   // 0 always ready, 1 random, 2 never ready

  always @(posedge trn_clk) begin
    #1;
    if (reset_n && (n_issued - n_cpl) > 0 &&
        (auto_cpl ? ($urandom_range(0, 2) == 0) : (n_cpl < cpl_budget))) begin
      rd_cpl_done = 1'b1;
      n_cpl++;
    end else begin
      rd_cpl_done = 1'b0;
    end
    case (rdy_mode)
      0:       trn_tdst_rdy_n = 1'b0;
      1:       trn_tdst_rdy_n = 1'($urandom_range(0, 1));
      default: trn_tdst_rdy_n = 1'b1;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic wait_issued(input int target, input int bound);
    for (int i = 0; i < bound && n_issued < target; i++) begin
      @(negedge trn_clk); #1;
    end
    check("issue_timeout", 64'(n_issued >= target), 64'd1);
  endtask

  task automatic wait_free(input int page, input int bound);
    bit got;
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge trn_clk); #1;
      if ((page == 1) ? huge_page_free_1 : huge_page_free_2) got = 1;
    end
    if (page == 1) huge_page_status_1 = 1'b0;
    else           huge_page_status_2 = 1'b0;
    check($sformatf("free%0d_timeout", page), 64'(got), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  int base;
  int qw_tab[3];

  initial begin
    cfg_completer_id = 16'($urandom);
    repeat (3) @(negedge trn_clk);
    #1;
    check("rst_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    check("rst_sof_eof", 64'({trn_tsof_n, trn_teof_n}), 64'd3);
    check("rst_td", trn_td, 64'd0);
    check("rst_trem", 64'(trn_trem_n), 64'd0);
    check("rst_free", 64'({huge_page_free_1, huge_page_free_2}), 64'd0);
    reset_n = 1'b1;

    // Page 1, 130 qwords: two full chunks and a 2-qword tail.
    base = n_issued;
    set_page(1, 64'h0000_0001_2340_0000, 130);
    huge_page_status_1 = 1'b1;
    wait_issued(base + 3, 200);
    repeat (10) @(negedge trn_clk);
    check("a_no_free_early", 64'(n_free), 64'd0);
    cpl_budget = n_cpl + 3;
    wait_free(1, 10);
    check("a_queue_empty", 64'(exp_q.size()), 64'd0);

    // Page 2 with zero qwords: no TLP, quick free.
    base = n_issued;
    set_page(2, rand_page_addr(), 0);
    huge_page_status_2 = 1'b1;
    wait_free(2, 5);
    check("b_no_tlp", 64'(n_issued - base), 64'd0);

    // Page 1, 640 qwords: outstanding limit stalls after 8 requests.
    base = n_issued;
    set_page(1, rand_page_addr(), 640);
    huge_page_status_1 = 1'b1;
    wait_issued(base + 8, 400);
    repeat (30) @(negedge trn_clk);
    #1;
    check("c_stall_count", 64'(n_issued - base), 64'd8);
    check("c_stall_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    cpl_budget = n_cpl + 1;
    repeat (30) @(negedge trn_clk);
    #1;
    check("c_one_more", 64'(n_issued - base), 64'd9);
    check("c_stall_tsrc2", 64'(trn_tsrc_rdy_n), 64'd1);
    auto_cpl = 1;
    rdy_mode = 1;
    wait_free(1, 2000);
    check("c_queue_empty", 64'(exp_q.size()), 64'd0);

    // Randomised pages with a back-pressured sink: pages 2, 1, 2.
    qw_tab[0] = 1;
    qw_tab[1] = 64;
    qw_tab[2] = $urandom_range(65, 400);
    for (int k = 0; k < 3; k++) begin
      set_page((k % 2 == 0) ? 2 : 1, rand_page_addr(), qw_tab[k]);
      if (k % 2 == 0) huge_page_status_2 = 1'b1;
      else            huge_page_status_1 = 1'b1;
      wait_free((k % 2 == 0) ? 2 : 1, 4000);
    end
    check("d_queue_empty", 64'(exp_q.size()), 64'd0);

    // Both unlocked: page 1, then page 2 although page 1 re-asserts.
    set_page(1, rand_page_addr(), 70);
    set_page(2, rand_page_addr(), 20);
    huge_page_status_1 = 1'b1;
    huge_page_status_2 = 1'b1;
    wait_free(1, 2000);
    set_page(1, rand_page_addr(), 10);
    huge_page_status_1 = 1'b1;
    wait_free(2, 2000);
    wait_free(1, 2000);
    check("e_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset while beat 2 of the second TLP is waiting (pointer is at page 2).
    auto_cpl   = 0;
    cpl_budget = n_cpl;
    rdy_mode   = 0;
    base = n_issued;
    set_page(2, rand_page_addr(), 192);
    huge_page_status_2 = 1'b1;
    wait_issued(base + 1, 200);
    rdy_mode = 2;
    repeat (3) @(negedge trn_clk);
    rdy_mode = 0;
    for (int i = 0; i < 10 && !hdr_seen; i++) begin
      @(negedge trn_clk); #1;
    end
    rdy_mode = 2;
    check("f_hdr_taken", 64'(hdr_seen), 64'd1);
    @(negedge trn_clk); #1;
    check("f_in_beat2", 64'({trn_tsrc_rdy_n, trn_teof_n}), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    check("f_async_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    check("f_async_td", trn_td, 64'd0);
    exp_q.delete();
    exp_tag     = 0;
    model_frees = n_free;
    set_page(1, rand_page_addr(), 100);
    set_page(2, rand_page_addr(), 64);
    huge_page_status_1 = 1'b1;
    huge_page_status_2 = 1'b1;
    repeat (3) @(negedge trn_clk);
    reset_n  = 1'b1;
    auto_cpl = 1;
    rdy_mode = 1;
    wait_free(1, 2000);
    wait_free(2, 2000);
    check("f_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef TX_HUGE_PAGE_RD_STATS_EN
    check("stats_req", 64'(rd_req_count), 64'd3);
    check("stats_pages", 64'(pages_done_count), 64'd2);
`endif

    repeat (5) @(negedge trn_clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
